div_unit: RTL
=============

# div_unit

Multi-cycle 32-bit signed/unsigned integer divider, one bit per cycle, placed beside the execute stage. Execute drives operands and `start_i` for DIV/DIVU and holds the pipeline through its stall request until `ready_o` rises. It then captures the 64-bit `{remainder, quotient}` into HI/LO.

## Interface
- No parameters. Width is fixed at 32.
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: reset, synchronous, active-high.
- `signed_div_i` input, 1: 1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i` input, 32: dividend.
- `opdata2_i` input, 32: divisor.
- `start_i` input, 1: request a divide. Held high by execute until it sees `ready_o`.
- `annul_i` input, 1: cancel the operation in flight (flush).
- `result_o` output, 64: `{remainder[31:0], quotient[31:0]}`. Registered.
- `ready_o` output, 1: result valid. Registered.

## Operation
- State register, 4 states:
  - FREE: idle.
    - On `start_i=1` and `annul_i=0`:
      - If `opdata2_i==0`, go to BYZERO.
      - Otherwise latch operands, convert them to magnitudes, clear `cnt`, go to ON.
    - Otherwise stay in FREE with `ready_o=0` and `result_o=0`.
  - BYZERO: load a zero working value and go to END.
  - ON: one iteration per cycle while `cnt<32`, with `cnt++`.
    - At `cnt==32`, do a finalize cycle: apply sign correction, load `result_o`, set `ready_o=1`, go to END.
    - If `annul_i=1` or `start_i=0` at any ON cycle, abort: go to FREE, `ready_o` stays 0, `cnt` is cleared.
  - END: hold `result_o` and `ready_o=1` while `start_i=1`.
    - When `start_i=0`: go to FREE, `ready_o←0`, `result_o←0`.
- Operand magnitude: when `signed_div_i=1` and bit31=1, the operand is replaced by `~x+1`. Unsigned operands pass through unchanged.
- Iteration uses a 65-bit working register `w`, initialised to `{32'b0, |dividend|, 1'b0}`.
  - Trial difference: `diff = {1'b0, w[63:32]} - {1'b0, |divisor|}` (33 bits).
  - If `diff[32]=1`: `w ← {w[63:0], 1'b0}`.
  - Else: `w ← {diff[31:0], w[31:0], 1'b1}`.
  - After 32 steps, quotient is `w[31:0]` and remainder is `w[64:33]`.
- Sign fix, applied only when `signed_div_i=1`:
  - Quotient is negated if `opdata1_i[31]` XOR `opdata2_i[31]`.
  - Remainder is negated if `opdata1_i[31]` is set.
  - Sign bits are taken from the operands latched at start.
- Division by zero: `result_o = 64'h0`, with no exception.
- Signed 0x80000000 / 0xFFFFFFFF wraps: quotient 0x80000000, remainder 0.
- Operand changes on `opdata*_i` after the start edge are ignored.

## Timing
- Reset (`rst=1` at an edge, from any state, including mid-ON):
  - state FREE, `cnt=0`, `w=0`, `ready_o=0`, `result_o=0`.
  - `rst` takes priority over `annul_i` and `start_i`.
- Let E0 be the edge at which FREE samples `start_i=1`.
  - Normal divide: edges E1..E32 perform the 32 iterations, and `ready_o=1` is visible after E33.
  - Divide by zero: `ready_o=1` after E2.
- `ready_o` stays high while `start_i=1`. It falls on the first edge that samples `start_i=0` in END.
- A new start is accepted in FREE only. Earliest back-to-back start is the edge after returning to FREE.
- `annul_i` in FREE or BYZERO: no effect on result. It blocks acceptance in FREE. BYZERO completes normally.
- `annul_i` in END: ignored. END exits only on `start_i=0`.
- Exactly one ready pulse sequence occurs per accepted start; none if aborted.

## Structure
- Shared `defines` package holds:
  - State encodings: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - RegBus and DoubleRegBus widths.
- One sub-module is natural: `div_step`, a purely combinational block.
  - Inputs: `w[64:0]` and divisor magnitude.
  - Output: next `w`.
  - It isolates the trial-subtract for unit test.
- `cnt` is 6 bits.

## Test plan
- Unsigned 100 / 7 with start held: `ready_o` high exactly after E33, `result_o = {32'd2, 32'd14}`. Holding start keeps it stable; dropping start gives `ready_o=0` and `result_o=0` one edge later.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → `{32'hFFFFFFFF, 32'hFFFFFFFD}`. Signed 7 / −2 → `{32'h1, 32'hFFFFFFFD}`.
- 5 / 0 (either sign mode): `ready_o` after E2, `result_o = 0`. Then unsigned 0xFFFFFFFF / 1 → `{0, 32'hFFFFFFFF}`.
- `annul_i` pulsed at `cnt=10`: FREE next edge, `ready_o` never rises. Then 9 / 3 → `{0, 3}` with full 33-cycle latency.
- Signed 0x80000000 / 0xFFFFFFFF → `{0, 32'h80000000}`. Unsigned same operands → `{32'h80000000, 0}`.
- `rst` asserted at `cnt=20`: next edge gives FREE, `ready_o=0`, `result_o=0`. `start_i` held during reset is not accepted until the first edge with `rst=0`.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: bus widths, FSM encoding,
// handshake levels and operand helpers.
package div_unit_pkg;

    localparam int RegBusW       = 32;
    localparam int DoubleRegBusW = 64;
    localparam int WorkW         = DoubleRegBusW + 1;
    localparam int CntW          = 6;

    localparam logic [CntW-1:0] CntDone = 6'd32;

    typedef logic [RegBusW-1:0]       reg_bus_t;
    typedef logic [DoubleRegBusW-1:0] double_reg_bus_t;
    typedef logic [WorkW-1:0]         work_t;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    function automatic reg_bus_t negate(input reg_bus_t x);
        return ~x + 1'b1;
    endfunction

    // Signed operands are iterated on as magnitudes; the sign is restored at the end.
    function automatic reg_bus_t abs_operand(input reg_bus_t x, input logic is_signed);
        return (is_signed && x[RegBusW-1]) ? negate(x) : x;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider connection. Execute (master) holds start_i high
// until it sees ready_o; the divider (slave) keeps ready_o/result_o stable
// for as long as start_i stays high, and drops both the edge after start_i falls.
interface div_unit_if;
    import div_unit_pkg::*;

    logic            signed_div_i;
    reg_bus_t        opdata1_i;
    reg_bus_t        opdata2_i;
    logic            start_i;
    logic            annul_i;
    double_reg_bus_t result_o;
    logic            ready_o;
    div_state_e      dbg_state_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, dbg_state_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, dbg_state_o
    );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: trial-subtract the divisor from the upper half
// of the working value and shift in the resulting quotient bit.
module div_unit_step
    import div_unit_pkg::*;
(
    input  work_t    w_i,
    input  reg_bus_t divisor_i,
    output work_t    w_o
);

    logic [RegBusW:0] diff;
    logic             unused_w_msb;

    assign diff         = {1'b0, w_i[63:32]} - {1'b0, divisor_i};
    // The top bit is shifted out by every step and never feeds the next one.
    assign unused_w_msb = w_i[64];

    always_comb begin
        if (diff[RegBusW]) begin
            w_o = {w_i[63:0], 1'b0};
        end else begin
            w_o = {diff[31:0], w_i[31:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider, one quotient bit per cycle.
// Result is {remainder, quotient}; divide-by-zero yields all zeros.
module div_unit
    import div_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave div
);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    work_t           w_q, w_d;
    reg_bus_t        divisor_q, divisor_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    double_reg_bus_t result_q, result_d;
    logic            ready_q, ready_d;

    work_t    w_step;
    reg_bus_t quot_raw;
    reg_bus_t rem_raw;
    logic     accept;
    logic     abort;
    logic     unused_w_gap;

    div_unit_step u_step (
        .w_i       (w_q),
        .divisor_i (divisor_q),
        .w_o       (w_step)
    );

    assign quot_raw     = w_q[31:0];
    assign rem_raw      = w_q[64:33];
    // Bit 32 only carries the last shifted-in zero between the two halves.
    assign unused_w_gap = w_q[32];

    assign accept = (div.start_i == DivStart) && !div.annul_i;
    assign abort  = div.annul_i || (div.start_i == DivStop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            w_q        <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DivFree: begin
                if (accept) begin
                    state_d = (div.opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: state_d = DivEnd;
            DivOn: begin
                if (abort) begin
                    state_d = DivFree;
                end else if (cnt_q == CntDone) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (div.start_i == DivStop) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        w_d        = w_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (accept && (div.opdata2_i != '0)) begin
                    w_d        = {32'b0, abs_operand(div.opdata1_i, div.signed_div_i), 1'b0};
                    divisor_d  = abs_operand(div.opdata2_i, div.signed_div_i);
                    cnt_d      = '0;
                    neg_quot_d = div.signed_div_i && (div.opdata1_i[31] ^ div.opdata2_i[31]);
                    neg_rem_d  = div.signed_div_i && div.opdata1_i[31];
                end
            end
            DivByZero: begin
                w_d = '0;
            end
            DivOn: begin
                if (abort) begin
                    cnt_d   = '0;
                    ready_d = DivResultNotReady;
                end else if (cnt_q != CntDone) begin
                    w_d   = w_step;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    result_d = {neg_rem_q ? negate(rem_raw) : rem_raw,
                                neg_quot_q ? negate(quot_raw) : quot_raw};
                    ready_d  = DivResultReady;
                    cnt_d    = '0;
                end
            end
            DivEnd: begin
                if (div.start_i == DivStop) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else begin
                    ready_d  = DivResultReady;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
            end
        endcase
    end

    assign div.result_o    = result_q;
    assign div.ready_o     = ready_q;
    assign div.dbg_state_o = state_q;

endmodule
